// File: rtl/fft_bfly_sched.sv
// Radix-2 DIF FFT butterfly sequencer: walks stages and butterflies,
// issuing data-pair and twiddle addresses with stall and inter-stage gap.
module fft_bfly_sched #(
    parameter int N    = 8,
    parameter int LOGN = 3,
    parameter int GAP  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall_i,
    output logic            valid_o,
    output logic [LOGN-1:0] stage_o,
    output logic [LOGN-2:0] bfly_o,
    output logic [LOGN-1:0] addr_a_o,
    output logic [LOGN-1:0] addr_b_o,
    output logic [LOGN-2:0] tw_addr_o,
    output logic            last_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int BW    = LOGN - 1;
    localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GLAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [GW-1:0]   gcnt;
    logic [LOGN-1:0] ld_s;
    logic [BW-1:0]   ld_b;
    logic [LOGN-1:0] ld_a;
    logic [LOGN-1:0] ld_span;
    logic [BW-1:0]   ld_k;
    logic            bmax;
    logic            fin;
    logic            load;

    function automatic logic [LOGN-1:0] span_of(input logic [LOGN-1:0] s);
        return LOGN'(N >> (int'(s) + 1));
    endfunction

    function automatic logic [LOGN-1:0] addr_of(input logic [LOGN-1:0] s,
                                                input logic [BW-1:0] b);
        int span;
        int j;
        int g;
        span = N >> (int'(s) + 1);
        j    = int'(b) & (span - 1);
        g    = int'(b) >> (LOGN - 1 - int'(s));
        return LOGN'(g * 2 * span + j);
    endfunction

    function automatic logic [BW-1:0] tw_of(input logic [LOGN-1:0] s,
                                            input logic [BW-1:0] b);
        int span;
        int j;
        span = N >> (int'(s) + 1);
        j    = int'(b) & (span - 1);
        return BW'(j << int'(s));
    endfunction

    assign bmax = (bfly_o == '1);
    assign fin  = bmax && (stage_o == LOGN'(LOGN - 1));

    // Next (s, b) to present whenever a new butterfly is loaded.
    always_comb begin
        ld_s = stage_o;
        ld_b = bfly_o;
        if (state == IDLE) begin
            ld_s = '0;
            ld_b = '0;
        end else if (state == DRAIN || bmax) begin
            ld_s = stage_o + 1'b1;
            ld_b = '0;
        end else begin
            ld_b = bfly_o + 1'b1;
        end
    end

    assign ld_a    = addr_of(ld_s, ld_b);
    assign ld_span = span_of(ld_s);
    assign ld_k    = tw_of(ld_s, ld_b);

    always_comb begin
        load = 1'b0;
        unique case (state)
            IDLE:    load = start;
            RUN:     load = !stall_i && !(bmax && (fin || GAP > 0));
            DRAIN:   load = (gcnt == GW'(GLAST));
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gcnt      <= '0;
            valid_o   <= 1'b0;
            stage_o   <= '0;
            bfly_o    <= '0;
            addr_a_o  <= '0;
            addr_b_o  <= '0;
            tw_addr_o <= '0;
            last_o    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (!stall_i && fin) begin
                        state   <= DONE;
                        valid_o <= 1'b0;
                        last_o  <= 1'b0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end else if (!stall_i && bmax && GAP > 0) begin
                        state   <= DRAIN;
                        valid_o <= 1'b0;
                        last_o  <= 1'b0;
                        gcnt    <= '0;
                    end
                end
                DRAIN: begin
                    if (gcnt == GW'(GLAST)) begin
                        state <= RUN;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (load) begin
                valid_o   <= 1'b1;
                stage_o   <= ld_s;
                bfly_o    <= ld_b;
                addr_a_o  <= ld_a;
                addr_b_o  <= ld_a + ld_span;
                tw_addr_o <= ld_k;
                last_o    <= (ld_b == '1);
            end
        end
    end

endmodule
